// File: rtl/mips_pkg.sv
// Shared constants and helpers for the MIPS operand-fetch slice.
//   DATA_W      operand / register width
//   REG_ADDR_W  register index width
//   IMM_W       immediate field width
//   SEL_W       ALU operation select width
package mips_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned IMM_W      = 16;
  localparam int unsigned SEL_W      = 2;
  localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;

  typedef enum logic [SEL_W-1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_e;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W - IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/reg_file_2r1w.sv
// 32-entry register file, two combinational read ports, one write port.
//   clk, rst          clock, synchronous active-high reset (clears all entries)
//   raddr_a/raddr_b   read indices; rdata_a/rdata_b read values
//   we/waddr/wdata    write port, committed at the rising edge
// R0 always reads zero and ignores writes. A write in the same cycle as a read of
// the same index is forwarded to the read port (write-first).
module reg_file_2r1w
  import mips_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] raddr_a,
  input  logic [REG_ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0]     rdata_a,
  output logic [DATA_W-1:0]     rdata_b,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we && (waddr != REG_ZERO)) begin
      regs_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = regs_q[raddr_a];
    if (raddr_a == REG_ZERO) begin
      rdata_a = '0;
    end else if (we && (waddr == raddr_a)) begin
      rdata_a = wdata;
    end
  end

  always_comb begin
    rdata_b = regs_q[raddr_b];
    if (raddr_b == REG_ZERO) begin
      rdata_b = '0;
    end else if (we && (waddr == raddr_b)) begin
      rdata_b = wdata;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Decode-to-execute stage feeding the ALU.
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready              issue handshake
//   rs, rt, imm, use_imm           operand sources; B = use_imm ? sext(imm) : R[rt]
//   alu_sel, rd                    passed through to sel / rd_out
//   wb_en, wb_addr, wb_data        register writeback (independent of stall)
//   stall_in                       downstream cannot take the current output
//   valid_out, inputA, inputB,     one-entry output register towards the ALU
//   sel, rd_out
module operand_fetch
  import mips_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [IMM_W-1:0]      imm,
  input  logic                  use_imm,
  input  logic [SEL_W-1:0]      alu_sel,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  stall_in,
  output logic                  valid_out,
  output logic [DATA_W-1:0]     inputA,
  output logic [DATA_W-1:0]     inputB,
  output logic [SEL_W-1:0]      sel,
  output logic [REG_ADDR_W-1:0] rd_out
);

  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;
  logic [DATA_W-1:0] operand_b;

  reg_file_2r1w u_reg_file (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data)
  );

  assign in_ready  = !valid_out || !stall_in;
  assign operand_b = use_imm ? sext_imm(imm) : rdata_b;

  // Data registers only load on accept so they hold through bubbles and stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      inputA    <= '0;
      inputB    <= '0;
      sel       <= '0;
      rd_out    <= '0;
    end else if (in_ready) begin
      valid_out <= in_valid;
      if (in_valid) begin
        inputA <= rdata_a;
        inputB <= operand_b;
        sel    <= alu_sel;
        rd_out <= rd;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;
  import mips_pkg::*;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  sel;
    logic [4:0]  rd;
  } op_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rs, rt, rd, wb_addr, rd_out;
  logic [15:0] imm;
  logic        use_imm, wb_en, stall_in, valid_out;
  logic [1:0]  alu_sel, sel;
  logic [31:0] wb_data, inputA, inputB;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] model_regs [32];
  op_t         exp_q [$];
  op_t         last_op;

  operand_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs        (rs),
    .rt        (rt),
    .imm       (imm),
    .use_imm   (use_imm),
    .alu_sel   (alu_sel),
    .rd        (rd),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .stall_in  (stall_in),
    .valid_out (valid_out),
    .inputA    (inputA),
    .inputB    (inputB),
    .sel       (sel),
    .rd_out    (rd_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] x);
    if (x == 0) return 32'd0;
    if (wb_en && wb_addr == x) return wb_data;
    return model_regs[x];
  endfunction

  // Reference model: an op is accepted whenever the one-entry stage is empty
  // (the monitor retires the resident op before the edge when it is consumed).
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
      exp_q.delete();
      last_op = '0;
    end else begin
      if (in_valid && exp_q.size() == 0) begin
        op_t o;
        o.a   = model_read(rs);
        o.b   = use_imm ? {{16{imm[15]}}, imm} : model_read(rt);
        o.sel = alu_sel;
        o.rd  = rd;
        exp_q.push_back(o);
        last_op = o;
      end
      if (wb_en && wb_addr != 0) model_regs[wb_addr] = wb_data;
    end
  end

  // Monitor: compares the presented output, retires it when downstream takes it.
  always @(negedge clk) begin
    chk("in_ready", {31'd0, in_ready}, {31'd0, (exp_q.size() == 0) || !stall_in});
    chk("valid_out", {31'd0, valid_out}, {31'd0, exp_q.size() != 0});
    if (valid_out && exp_q.size() != 0) begin
      chk("inputA", inputA, exp_q[0].a);
      chk("inputB", inputB, exp_q[0].b);
      chk("sel", {30'd0, sel}, {30'd0, exp_q[0].sel});
      chk("rd_out", {27'd0, rd_out}, {27'd0, exp_q[0].rd});
      if (!stall_in) void'(exp_q.pop_front());
    end else if (!valid_out) begin
      chk("holdA", inputA, last_op.a);
      chk("holdB", inputB, last_op.b);
      chk("hold_sel", {30'd0, sel}, {30'd0, last_op.sel});
      chk("hold_rd", {27'd0, rd_out}, {27'd0, last_op.rd});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; rs = 0; rt = 0; imm = 0; use_imm = 0; alu_sel = 0; rd = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0;
  endtask

  task automatic issue(input logic [4:0] a, input logic [4:0] b, input logic ui,
                       input logic [15:0] im, input logic [1:0] s, input logic [4:0] d);
    in_valid = 1; rs = a; rt = b; use_imm = ui; imm = im; alu_sel = s; rd = d;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] v);
    wb_en = 1; wb_addr = a; wb_data = v;
  endtask

  task automatic read_all_regs();
    for (int i = 1; i < 32; i += 2) begin
      issue(5'(i), 5'(i + 1 < 32 ? i + 1 : 0), 0, 16'd0, 2'd0, 5'(i));
      step();
    end
    idle_inputs();
    step();
  endtask

  initial begin
    rst = 1; stall_in = 0;
    idle_inputs();
    step(); step();
    rst = 0;
    step();
    read_all_regs();

    // Register operands
    write_reg(5'd1, 32'd5001); step();
    write_reg(5'd2, 32'd3001); step();
    idle_inputs();
    issue(5'd1, 5'd2, 0, 16'd0, 2'd1, 5'd3); step();
    // Immediates
    issue(5'd1, 5'd0, 1, 16'hFFFF, 2'd0, 5'd4); step();
    issue(5'd1, 5'd0, 1, 16'h1F42, 2'd2, 5'd6); step();
    // Same-cycle bypass, then R0 write dropped
    write_reg(5'd5, 32'd8006001);
    issue(5'd5, 5'd0, 0, 16'd0, 2'd3, 5'd7); step();
    write_reg(5'd0, 32'd7);
    issue(5'd0, 5'd0, 0, 16'd0, 2'd0, 5'd8); step();
    idle_inputs();
    issue(5'd0, 5'd5, 0, 16'd0, 2'd0, 5'd9); step();
    idle_inputs(); step();

    // Stall with a pending new op, writeback during stall
    issue(5'd2, 5'd1, 0, 16'd0, 2'd1, 5'd10); step();
    stall_in = 1;
    issue(5'd1, 5'd2, 0, 16'd0, 2'd2, 5'd11);
    write_reg(5'd2, 32'd42);
    repeat (3) step();
    wb_en = 0;
    stall_in = 0; step();
    idle_inputs(); step(); step();

    // Reset while stalled
    issue(5'd5, 5'd1, 0, 16'd0, 2'd3, 5'd12); step();
    stall_in = 1; idle_inputs(); step();
    rst = 1; step();
    rst = 0; stall_in = 0; step();
    read_all_regs();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      in_valid = 1'($urandom_range(0, 3) != 0);
      rs       = 5'($urandom_range(0, 31));
      rt       = 5'($urandom_range(0, 31));
      use_imm  = 1'($urandom_range(0, 1));
      imm      = 16'($urandom);
      alu_sel  = 2'($urandom_range(0, 3));
      rd       = 5'($urandom_range(0, 31));
      wb_en    = 1'($urandom_range(0, 1));
      wb_addr  = 5'($urandom_range(0, 31));
      wb_data  = $urandom;
      stall_in = 1'($urandom_range(0, 9) < 3);
      step();
    end

    // Drain with a bounded wait
    idle_inputs();
    stall_in = 0;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d ops outstanding, expected 0", exp_q.size());
    end
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
